// File: rtl/alu_bus_unit.sv
// Bus-side ALU: latches operands from the internal bus, computes on a latch strobe, drives result when enabled.
// Optional shift-add multiplier (op 1000) compiled in when ALU_BUS_MUL_EN is defined.
module alu_bus_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        alu_in1,
  input  logic        alu_in2,
  input  logic        alu_outlatch,
  input  logic        alu_out_en,
  input  logic [3:0]  op,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        busy,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_n,
  output logic        err
);

  logic [15:0] op_a, op_b, result;
  logic [15:0] alu_r;
  logic        alu_c, op_ok;
  logic [16:0] wide;
  logic        start_mul, single_write, err_next;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    op_ok = 1'b1;
    wide  = '0;
    case (op)
      4'b0001: begin
        wide  = {1'b0, op_a} + {1'b0, op_b};
        alu_r = wide[15:0];
        alu_c = wide[16];
      end
      4'b0010: begin
        alu_r = op_a - op_b;
        alu_c = (op_a < op_b);
      end
      4'b0011: alu_r = op_a & op_b;
      4'b0100: alu_r = op_a | op_b;
      4'b0101: alu_r = op_a ^ op_b;
      // The extra 17th bit catches the last bit shifted out; it stays 0 for a zero shift.
      4'b0110: begin
        wide  = {1'b0, op_a} << op_b[3:0];
        alu_r = wide[15:0];
        alu_c = wide[16];
      end
      4'b0111: begin
        wide  = {op_a, 1'b0} >> op_b[3:0];
        alu_r = wide[16:1];
        alu_c = wide[0];
      end
`ifdef ALU_BUS_MUL_EN
      4'b1000: op_ok = 1'b1;
`endif
      default: op_ok = 1'b0;
    endcase
  end

`ifdef ALU_BUS_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t      state, state_next;
  logic [15:0] mul_a, mul_b;
  logic [31:0] acc, acc_next;
  logic [3:0]  cnt;
  logic        mul_done;

  assign busy      = (state == S_MUL);
  assign start_mul = alu_outlatch & ~busy & (op == 4'b1000);
  assign mul_done  = busy & (cnt == 4'd15);
  assign acc_next  = acc + (mul_b[cnt] ? ({16'h0000, mul_a} << cnt) : 32'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_mul) state_next = S_MUL;
      S_MUL:   if (cnt == 4'd15) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Multiplier works on private copies so operand loads stay legal while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start_mul) begin
      mul_a <= op_a;
      mul_b <= op_b;
      acc   <= '0;
      cnt   <= '0;
    end else if (busy) begin
      acc <= acc_next;
      cnt <= cnt + 4'd1;
    end
  end
`else
  assign busy      = 1'b0;
  assign start_mul = 1'b0;
`endif

  assign single_write = alu_outlatch & ~busy & ~start_mul;
  assign err_next     = (alu_outlatch & (busy | ~op_ok)) | (alu_out_en & busy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (alu_in1) op_a <= bus_in;
      if (alu_in2) op_b <= bus_in;
      err <= err_next;
      if (single_write) begin
        result <= alu_r;
        flag_z <= (alu_r == 16'h0000);
        flag_c <= alu_c;
        flag_n <= alu_r[15];
      end
`ifdef ALU_BUS_MUL_EN
      else if (mul_done) begin
        result <= acc_next[15:0];
        flag_z <= (acc_next[15:0] == 16'h0000);
        flag_c <= |acc_next[31:16];
        flag_n <= acc_next[15];
      end
`endif
    end
  end

  assign bus_drive = alu_out_en & ~busy;
  assign bus_out   = bus_drive ? result : 16'h0000;

endmodule

// File: tb/tb_alu_bus_unit.sv
// Self-checking bench for alu_bus_unit: directed vector table, random ops against a reference model, MUL/reset corners.
module tb_alu_bus_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        alu_in1, alu_in2, alu_outlatch, alu_out_en;
  logic [3:0]  op;
  logic [15:0] bus_out;
  logic        bus_drive, busy, flag_z, flag_c, flag_n, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_bus_unit dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_outlatch(alu_outlatch), .alu_out_en(alu_out_en), .op(op),
    .bus_out(bus_out), .bus_drive(bus_drive), .busy(busy),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .err(err)
  );

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  opc;
    logic [15:0] r;
    logic        c, e;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each op.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] opc,
                                    output logic [15:0] r, output logic c, output logic e);
    longint p;
    int     s;
    s = int'(b[3:0]);
    r = 16'h0; c = 1'b0; e = 1'b0;
    case (opc)
      4'd1: begin p = longint'(a) + longint'(b); r = p[15:0]; c = (p > 65535); end
      4'd2: begin r = a - b; c = (a < b); end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: begin p = longint'(a) << s; r = p[15:0]; c = (s != 0) && p[16]; end
      4'd7: begin r = a >> s; c = (s == 0) ? 1'b0 : ((a >> (s - 1)) & 16'h1) != 0; end
`ifdef ALU_BUS_MUL_EN
      4'd8: begin p = longint'(a) * longint'(b); r = p[15:0]; c = (p >> 16) != 0; end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] opc,
                               input logic [15:0] er, input logic ec, input logic ee);
    int n, ebusy;
    ebusy = 0;
`ifdef ALU_BUS_MUL_EN
    if (opc == 4'd8) ebusy = 16;
`endif
    @(negedge clk); bus_in = a; alu_in1 = 1'b1;
    @(negedge clk); bus_in = b; alu_in1 = 1'b0; alu_in2 = 1'b1;
    @(negedge clk); alu_in2 = 1'b0; op = opc; alu_outlatch = 1'b1;
    @(negedge clk); alu_outlatch = 1'b0;
    checkOutput("err_after_latch", err, ee);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", n, ebusy);
    alu_out_en = 1'b1;
    #1;
    checkOutput("bus_out", bus_out, er);
    checkOutput("bus_drive", bus_drive, 1'b1);
    checkOutput("flag_z", flag_z, er == 16'h0);
    checkOutput("flag_c", flag_c, ec);
    checkOutput("flag_n", flag_n, er[15]);
    @(negedge clk); alu_out_en = 1'b0;
    checkOutput("err_pulse_end", err, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] ra, rb, rr;
    logic [3:0]  ro;
    logic        rc, re;
    int          cyc;

    rst = 1'b1; bus_in = '0; alu_in1 = 0; alu_in2 = 0; alu_outlatch = 0; alu_out_en = 0; op = '0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_bus_out", bus_out, 0);
    checkOutput("rst_drive", bus_drive, 0);
    checkOutput("rst_flags", {flag_z, flag_c, flag_n}, 0);
    checkOutput("rst_err", err, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    alu_out_en = 1'b1; #1;
    checkOutput("rst_result", bus_out, 16'h0000);
    alu_out_en = 1'b0;

    vecs.push_back('{16'h0005, 16'h0003, 4'd1, 16'h0008, 1'b0, 1'b0});
    vecs.push_back('{16'h0003, 16'h0005, 4'd2, 16'hFFFE, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 4'd1, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h8001, 16'h0001, 4'd6, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{16'h8001, 16'h0000, 4'd7, 16'h8001, 1'b0, 1'b0});
    vecs.push_back('{16'hF0F0, 16'h0FF0, 4'd3, 16'h00F0, 1'b0, 1'b0});
    vecs.push_back('{16'hF0F0, 16'h0F0F, 4'd4, 16'hFFFF, 1'b0, 1'b0});
    vecs.push_back('{16'hAAAA, 16'hAAAA, 4'd5, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h000F, 4'd7, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{16'h0001, 16'h000F, 4'd6, 16'h8000, 1'b0, 1'b0});
    vecs.push_back('{16'h0003, 16'h0001, 4'd7, 16'h0001, 1'b1, 1'b0});
    vecs.push_back('{16'h1234, 16'h5678, 4'd15, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h5678, 4'd0, 16'h0000, 1'b0, 1'b1});
`ifdef ALU_BUS_MUL_EN
    vecs.push_back('{16'h0012, 16'h0034, 4'd8, 16'h03A8, 1'b0, 1'b0});
    vecs.push_back('{16'h0100, 16'h0100, 4'd8, 16'h0000, 1'b1, 1'b0});
`else
    vecs.push_back('{16'h0012, 16'h0034, 4'd8, 16'h0000, 1'b0, 1'b1});
`endif
    foreach (vecs[i])
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].opc, vecs[i].r, vecs[i].c, vecs[i].e);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ro = 4'($urandom_range(0, 15));
      ref_model(ra, rb, ro, rr, rc, re);
      applyStimulus(ra, rb, ro, rr, rc, re);
    end

`ifdef ALU_BUS_MUL_EN
    applyStimulus(16'h0012, 16'h0034, 4'd1, 16'h0046, 1'b0, 1'b0);
    @(negedge clk); bus_in = 16'h0012; alu_in1 = 1'b1;
    @(negedge clk); bus_in = 16'h0034; alu_in1 = 1'b0; alu_in2 = 1'b1;
    @(negedge clk); alu_in2 = 1'b0; op = 4'd8; alu_outlatch = 1'b1;
    @(negedge clk); alu_outlatch = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      case (cyc)
        1: begin
          alu_out_en = 1'b1; #1;
          checkOutput("busy_drive", bus_drive, 1'b0);
          checkOutput("busy_bus_out", bus_out, 16'h0000);
        end
        2: begin
          alu_out_en = 1'b0;
          checkOutput("err_outen_busy", err, 1'b1);
          alu_outlatch = 1'b1; op = 4'd1;
        end
        3: begin
          alu_outlatch = 1'b0;
          checkOutput("err_latch_busy", err, 1'b1);
          alu_in1 = 1'b1; bus_in = 16'hFFFF;
        end
        4: begin
          alu_in1 = 1'b0;
          checkOutput("err_clears_busy", err, 1'b0);
        end
        default: ;
      endcase
      cyc++;
      @(negedge clk);
    end
    checkOutput("mul_busy_len", cyc, 16);
    alu_out_en = 1'b1; #1;
    checkOutput("mul_result_private", bus_out, 16'h03A8);
    checkOutput("mul_flag_c", flag_c, 1'b0);
    @(negedge clk); alu_out_en = 1'b0;
`endif

    // Reset while a result with nonzero flags is held (and mid-MUL when present).
    applyStimulus(16'h8000, 16'h0001, 4'd1, 16'h8001, 1'b0, 1'b0);
`ifdef ALU_BUS_MUL_EN
    @(negedge clk); op = 4'd8; alu_outlatch = 1'b1;
    @(negedge clk); alu_outlatch = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("busy_mid_mul", busy, 1'b1);
`endif
    rst = 1'b1; alu_out_en = 1'b1; #1;
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_flags", {flag_z, flag_c, flag_n}, 0);
    checkOutput("rst_mid_bus", bus_out, 16'h0000);
    @(negedge clk); rst = 1'b0; alu_out_en = 1'b0;
    applyStimulus(16'h0005, 16'h0003, 4'd1, 16'h0008, 1'b0, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_bus_unit.md
# alu_bus_unit

Bus-side ALU datapath: the responder to the instruction FSMs' ALU control strobes. It latches operands from the shared 16-bit internal bus and computes on a latch strobe. It then drives the result back onto the bus when output-enabled. One instance sits between the shared bus and the general/port register file, and ALU/ALUI controller outputs connect directly to its strobe inputs.

## Interface

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- bus_in  in  16  shared internal bus value
- alu_in1  in  1  latch operand A from bus_in
- alu_in2  in  1  latch operand B from bus_in
- alu_outlatch  in  1  capture op and compute result
- alu_out_en  in  1  request result onto bus
- op  in  4  operation code, sampled with alu_outlatch
- bus_out  out  16  result to bus; 0 when not driving
- bus_drive  out  1  bus_out valid / tristate enable
- busy  out  1  multi-cycle operation in progress
- flag_z, flag_c, flag_n  out  1 each  zero / carry-borrow / sign of last result
- err  out  1  one-cycle pulse on illegal op or strobe while busy

## Operation

Operand capture:
- All strobes are sampled at posedge clk.
- alu_in1 loads opA <= bus_in; alu_in2 loads opB <= bus_in.
- If both are asserted in the same cycle, both registers load the same value.
- Operand loads are legal while busy; the multiplier works on private copies.

Op codes:
- 0001 ADD: {C,R} = A+B (17-bit sum).
- 0010 SUB: R = A-B; C = 1 if A<B (borrow).
- 0011 AND, 0100 OR, 0101 XOR: C=0.
- 0110 SHL and 0111 SHR (logical), shift amount B[3:0]:
  - C = last bit shifted out.
  - C = 0 when the amount is 0.
- 1000 MUL: R = low 16 bits of A*B; C = 1 if the high 16 bits are nonzero. Only present with the macro; see Configuration.
- Any other code: R = 0, Z=1, C=0, N=0, err pulses.

Flags:
- Z = (R==0), N = R[15].
- Flags update only when the result register updates.

State machine:
- IDLE
  - alu_outlatch with a single-cycle op: result and flags written at that edge; stay in IDLE.
  - alu_outlatch with MUL: copy A and B to working registers, clear accumulator, counter=0, go to MUL.
- MUL
  - One shift-add step per clock, 16 steps.
  - At the edge where counter==15: write result and flags, return to IDLE.
  - alu_outlatch while in MUL: ignored; err pulses; op and result unchanged.

Bus output:
- bus_drive = alu_out_en & ~busy; bus_out = bus_drive ? result : 16'h0000.
- alu_out_en while busy: bus_drive stays 0, err pulses.

## Timing

- Reset: opA, opB, result=0; flags 0; busy=0; err=0; bus_out=0; bus_drive=0; state IDLE.
- Reset mid-MUL aborts the multiply immediately; there is no partial result.
- Single-cycle op latency:
  - alu_outlatch sampled at edge N; result visible after edge N.
  - alu_out_en in cycle N+1 places it on the bus.
  - This matches the controller sequence latch→enable in consecutive states.
- bus_out/bus_drive are combinational from alu_out_en and registered state, with no added cycle.
- MUL latency:
  - busy rises after edge N and stays high for 16 cycles.
  - Result written and busy cleared at edge N+16.
  - alu_out_en is honoured from cycle N+16.
- err is registered, high exactly one cycle after the offending sample.
- A/B are never modified by compute. Back-to-back alu_outlatch in IDLE recomputes each cycle with the current op.

## Configuration

- ALU_BUS_MUL_EN defined:
  - MUL state, working registers and counter are compiled in.
  - op 1000 behaves as described above.
- ALU_BUS_MUL_EN undefined:
  - No MUL logic; busy is tied 0.
  - op 1000 is treated as an undefined op: R=0, Z=1, err pulse.

## Test plan

- ADD: bus 0x0005 w/ alu_in1, 0x0003 w/ alu_in2, op 0001 + outlatch, then out_en -> bus_out=0x0008, drive=1, Z=0,C=0,N=0.
- SUB borrow: A=0x0003, B=0x0005, op 0010 -> 0xFFFE, C=1, N=1; ADD 0xFFFF+0x0001 -> 0x0000, Z=1, C=1.
- Shift: A=0x8001, B=0x0001, op 0110 -> 0x0002, C=1; op 0111 with B=0x0000 -> 0x8001, C=0.
- MUL (macro on): A=0x0012, B=0x0034, op 1000 -> busy high exactly 16 cycles, then 0x03A8, C=0. Out_en during busy -> drive=0, err pulse. Outlatch during busy -> err pulse, result unchanged.
- Illegal op 1111 (and 1000 with macro off) -> result 0x0000, Z=1, err one-cycle pulse, busy never set.
- Reset asserted on cycle 8 of MUL -> busy=0, result=0, flags 0 immediately; the next ADD completes normally.
